// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared sizes, controller state codes and scheduler states
package elevator_pkg;

    localparam int NUM_FLOORS = 8;
    localparam int FLOOR_W    = 3;

    localparam logic [2:0] CTRL_IDLE    = 3'b000;
    localparam logic [2:0] CTRL_MOVE_UP = 3'b001;
    localparam logic [2:0] CTRL_MOVE_DN = 3'b010;
    localparam logic [2:0] CTRL_DOOR    = 3'b011;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PICK   = 3'd1,
        S_ISSUE  = 3'd2,
        S_DEPART = 3'd3,
        S_TRAVEL = 3'd4
    } sched_state_t;

endpackage

// File: rtl/request_scheduler_if.sv
// rtl/request_scheduler_if.sv - scheduler <-> elevator controller destination handshake
interface request_scheduler_if #(
    parameter int FLOOR_W = elevator_pkg::FLOOR_W
);
    logic [FLOOR_W-1:0] current_floor;
    logic [2:0]         ctrl_state;
    logic [FLOOR_W-1:0] dest_floor;
    logic               input_h;

    modport master (
        input  current_floor,
        input  ctrl_state,
        output dest_floor,
        output input_h
    );

    modport slave (
        output current_floor,
        output ctrl_state,
        input  dest_floor,
        input  input_h
    );
endinterface

// File: rtl/floor_picker.sv
// rtl/floor_picker.sv - combinational sweep-order selection of the next destination floor
module floor_picker #(
    parameter int NUM_FLOORS = elevator_pkg::NUM_FLOORS,
    parameter int FLOOR_W    = elevator_pkg::FLOOR_W
) (
    input  logic [NUM_FLOORS-1:0] i_pending,
    input  logic [FLOOR_W-1:0]    i_current_floor,
    input  logic                  i_sweep_up,
    output logic                  o_found,
    output logic [FLOOR_W-1:0]    o_target,
    output logic                  o_new_sweep_up
);
    logic               w_cur_valid;
    logic               w_at_cur;
    logic               w_any_above;
    logic               w_any_below;
    logic [FLOOR_W-1:0] w_lo_above;
    logic [FLOOR_W-1:0] w_hi_below;

    // Descending scan leaves the lowest floor above; ascending scan leaves the highest below.
    always_comb begin
        w_cur_valid = int'(i_current_floor) < NUM_FLOORS;
        w_at_cur    = 1'b0;
        w_any_above = 1'b0;
        w_any_below = 1'b0;
        w_lo_above  = '0;
        w_hi_below  = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (i_pending[i] && (FLOOR_W'(i) > i_current_floor)) begin
                w_any_above = 1'b1;
                w_lo_above  = FLOOR_W'(i);
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i_pending[i] && (FLOOR_W'(i) < i_current_floor)) begin
                w_any_below = 1'b1;
                w_hi_below  = FLOOR_W'(i);
            end
            if (i_pending[i] && (FLOOR_W'(i) == i_current_floor)) begin
                w_at_cur = 1'b1;
            end
        end
    end

    always_comb begin
        o_found        = 1'b0;
        o_target       = i_current_floor;
        o_new_sweep_up = i_sweep_up;
        if (w_cur_valid) begin
            if (w_at_cur) begin
                o_found = 1'b1;
            end else if (i_sweep_up) begin
                if (w_any_above) begin
                    o_found  = 1'b1;
                    o_target = w_lo_above;
                end else if (w_any_below) begin
                    o_found        = 1'b1;
                    o_target       = w_hi_below;
                    o_new_sweep_up = 1'b0;
                end
            end else begin
                if (w_any_below) begin
                    o_found  = 1'b1;
                    o_target = w_hi_below;
                end else if (w_any_above) begin
                    o_found        = 1'b1;
                    o_target       = w_lo_above;
                    o_new_sweep_up = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/request_scheduler.sv
// rtl/request_scheduler.sv - elevator call latch and destination scheduler FSM
module request_scheduler #(
    parameter int NUM_FLOORS = elevator_pkg::NUM_FLOORS,
    parameter int FLOOR_W    = elevator_pkg::FLOOR_W
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [NUM_FLOORS-1:0] i_call_req,
    output logic [NUM_FLOORS-1:0] o_pending,
    output logic                  o_sweep_up,
    request_scheduler_if.master   bus
);
    import elevator_pkg::*;

    sched_state_t          r_state;
    sched_state_t          w_state_nxt;
    logic [NUM_FLOORS-1:0] r_call_d;
    logic [NUM_FLOORS-1:0] r_pending;
    logic [NUM_FLOORS-1:0] w_set;
    logic [NUM_FLOORS-1:0] w_clr;
    logic [NUM_FLOORS-1:0] w_dest_mask;
    logic [NUM_FLOORS-1:0] w_pending_nxt;
    logic [FLOOR_W-1:0]    r_dest;
    logic                  r_sweep_up;
    logic [1:0]            r_dep_cnt;
    logic                  w_found;
    logic                  w_new_sweep;
    logic [FLOOR_W-1:0]    w_target;
    logic                  w_ctrl_idle;
    logic                  w_others;
    logic                  w_load;
    logic                  w_clr_en;
    logic                  w_input_h;
    logic                  w_cnt_clr;
    logic                  w_cnt_inc;

    assign w_ctrl_idle = (bus.ctrl_state == CTRL_IDLE);

    floor_picker #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_picker (
        .i_pending       (r_pending),
        .i_current_floor (bus.current_floor),
        .i_sweep_up      (r_sweep_up),
        .o_found         (w_found),
        .o_target        (w_target),
        .o_new_sweep_up  (w_new_sweep)
    );

    // A press at the floor where an idle car already stands is served on the spot.
    // The arrival clear is applied after the set so it wins a same-cycle collision.
    always_comb begin
        w_set       = i_call_req & ~r_call_d;
        w_dest_mask = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if ((FLOOR_W'(i) == bus.current_floor) && w_ctrl_idle && (r_state == S_IDLE)) begin
                w_set[i] = 1'b0;
            end
            if (FLOOR_W'(i) == r_dest) begin
                w_dest_mask[i] = 1'b1;
            end
        end
        w_clr         = w_clr_en ? w_dest_mask : '0;
        w_others      = |(r_pending & ~w_dest_mask);
        w_pending_nxt = (r_pending | w_set) & ~w_clr;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_clr_en    = 1'b0;
        w_input_h   = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|r_pending) w_state_nxt = S_PICK;
            end
            S_PICK: begin
                if (w_found) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_ISSUE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (w_ctrl_idle) begin
                    w_input_h   = 1'b1;
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = S_DEPART;
                end
            end
            S_DEPART: begin
                // Controller never leaving idle means the car was already at the destination.
                if (!w_ctrl_idle) begin
                    w_state_nxt = S_TRAVEL;
                end else if (r_dep_cnt == 2'd2) begin
                    w_clr_en    = 1'b1;
                    w_state_nxt = w_others ? S_PICK : S_IDLE;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            S_TRAVEL: begin
                if (w_ctrl_idle) begin
                    w_clr_en    = 1'b1;
                    w_state_nxt = w_others ? S_PICK : S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_call_d   <= '0;
            r_pending  <= '0;
            r_dest     <= '0;
            r_sweep_up <= 1'b1;
            r_dep_cnt  <= 2'd0;
        end else begin
            r_call_d  <= i_call_req;
            r_pending <= w_pending_nxt;
            if (w_load) begin
                r_dest     <= w_target;
                r_sweep_up <= w_new_sweep;
            end
            if (w_cnt_clr) begin
                r_dep_cnt <= 2'd0;
            end else if (w_cnt_inc) begin
                r_dep_cnt <= r_dep_cnt + 2'd1;
            end
        end
    end

    assign bus.dest_floor = r_dest;
    assign bus.input_h    = w_input_h;
    assign o_pending      = r_pending;
    assign o_sweep_up     = r_sweep_up;
endmodule
